dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter for the single-ported data memory (`dmem`). The CPU is the default owner; a secondary requester (DMA/coprocessor engine) obtains the bus through a hold / hold-acknowledge handshake with the main decoder, bursts word accesses, then returns ownership. The block sits between the datapath's memory stage, the secondary master and `dmem`, and drives the decoder's `hold` input.

## Interface
- WIDE, 32, data word width
- MAX_BURST, 8, max DMA beats per grant (≥1)
- ACK_TIMEOUT, 16, cycles in HOLD without ack before abort (≥1)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_we  in  1  CPU store strobe
- cpu_addr  in  32  CPU byte address
- cpu_wd  in  WIDE  CPU store data
- cpu_rd  out  WIDE  load data to CPU (= mem_rd, always)
- hold  out  1  hold request to main decoder
- hold_ack  in  1  decoder hold acknowledge
- dma_req  in  1  DMA wants the bus; held high for whole burst
- dma_valid  in  1  DMA access this cycle
- dma_we  in  1  DMA write strobe
- dma_addr  in  32  DMA byte address
- dma_wd  in  WIDE  DMA write data
- dma_rd  out  WIDE  read data to DMA (= mem_rd, always)
- dma_gnt  out  1  DMA owns the bus
- mem_we  out  1  to dmem we
- mem_addr  out  32  to dmem a
- mem_wd  out  WIDE  to dmem d
- mem_rd  in  WIDE  from dmem q (combinational read)
- err  out  1  sticky: ack timeout occurred
- grants  out  16  number of completed grants, wraps at 0xFFFF→0

## Operation
- States: IDLE, HOLD, GRANT, COOL; state register only, outputs Moore-decoded.
- IDLE: hold=0, dma_gnt=0, mux→CPU. dma_req=1 → HOLD; wait counter cleared.
- HOLD: hold=1, dma_gnt=0, mux→CPU (CPU finishes in-flight access). Priority: dma_req=0 → IDLE; else hold_ack=1 → GRANT (beat counter cleared); else wait counter +1; counter reaching ACK_TIMEOUT → COOL, err←1.
- GRANT: hold=1, dma_gnt=1, mux→DMA. Beat = dma_req & dma_valid. Exit to COOL when dma_req=0, or when a beat occurs with beat count = MAX_BURST-1 (MAX_BURST-th beat); grants +1 on every GRANT→COOL.
- COOL: hold=0, dma_gnt=0, mux→CPU, exactly one cycle → IDLE; dma_req ignored (guarantees CPU ≥2 cycles between grants: COOL + IDLE).
- Mux: when dma_gnt, mem_addr=dma_addr, mem_wd=dma_wd, mem_we=dma_req&dma_valid&dma_we; otherwise CPU signals pass through, mem_we=cpu_we. Combinational from state and inputs.
- dma_valid/dma_we outside GRANT never reach memory.
- err cleared only by rst. grants unsigned 16-bit wrap.

## Timing
- Reset values: state IDLE, hold=0, dma_gnt=0, err=0, grants=0, counters 0; mux→CPU immediately on rst assertion (async), including mid-burst; a DMA write in that cycle is dropped.
- dma_req high sampled at edge N (IDLE) → hold=1 in cycle N+1. hold_ack high in N+1 → dma_gnt=1 in N+2; earliest DMA beat in N+2.
- Read latency 0: dma_rd valid in same cycle as beat. Writes commit at edge ending beat cycle.
- dma_req low sampled at edge M (GRANT) → dma_gnt=0, hold=0 from M+1 (COOL); IDLE from M+2; new HOLD earliest M+3.
- HOLD with dma_req=0 and hold_ack=1 same cycle → IDLE (drop wins).
- Timeout: ACK_TIMEOUT full HOLD cycles without ack → COOL, err=1 from next cycle.
- MAX_BURST=1: single beat then COOL.

## Test plan
- Reset: rst pulse mid-GRANT with dma_we=1 → hold=0, dma_gnt=0, mem_we=cpu_we same cycle, no DMA write visible in dmem.
- CPU-only: dma_req=0, CPU sw 0xDEADBEEF to 0x40 then lw → cpu_rd=0xDEADBEEF, hold stays 0.
- Basic burst: dma_req at edge 0, hold_ack tied to hold, 3 DMA writes 0x100..0x108 then dma_req=0 → dma_gnt high cycles 2–5, dmem holds values, grants=1, hold low from cycle 6.
- Burst cap: MAX_BURST=8, dma_req held high with 12 valid writes → exactly 8 beats, COOL+IDLE 2 cycles, regrant, remaining 4 beats complete, grants=2.
- Timeout: hold_ack held 0, dma_req=1 → after 16 HOLD cycles err=1, dma_gnt never asserted, hold drops, re-request cycle repeats.
- Race: in HOLD drive dma_req=0 and hold_ack=1 same cycle → next state IDLE, dma_gnt stays 0, grants unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the CPU and a
// DMA master using a hold / hold-acknowledge handshake.
module dmem_arbiter #(
  parameter int WIDE        = 32,
  parameter int MAX_BURST   = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_we,
  input  logic [31:0]     cpu_addr,
  input  logic [WIDE-1:0] cpu_wd,
  output logic [WIDE-1:0] cpu_rd,
  output logic            hold,
  input  logic            hold_ack,
  input  logic            dma_req,
  input  logic            dma_valid,
  input  logic            dma_we,
  input  logic [31:0]     dma_addr,
  input  logic [WIDE-1:0] dma_wd,
  output logic [WIDE-1:0] dma_rd,
  output logic            dma_gnt,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [WIDE-1:0] mem_wd,
  input  logic [WIDE-1:0] mem_rd,
  output logic            err,
  output logic [15:0]     grants
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GRANT,
    COOL
  } state_t;

  localparam int WW = $clog2(ACK_TIMEOUT + 1);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [WW-1:0] WLAST = WW'(ACK_TIMEOUT - 1);
  localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);

  state_t        state, nxt;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          err_set;
  logic          done;
  logic          beat;

  assign beat = dma_req & dma_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wcnt   <= '0;
      bcnt   <= '0;
      err    <= 1'b0;
      grants <= '0;
    end else begin
      state <= nxt;
      wcnt  <= wcnt_n;
      bcnt  <= bcnt_n;
      if (err_set)
        err <= 1'b1;
      if (done)
        grants <= grants + 16'd1;
    end
  end

  always_comb begin
    nxt     = state;
    wcnt_n  = wcnt;
    bcnt_n  = bcnt;
    err_set = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        wcnt_n = '0;
        if (dma_req)
          nxt = HOLD;
      end
      HOLD: begin
        // a dropped request beats a same-cycle acknowledge
        if (!dma_req) begin
          nxt = IDLE;
        end else if (hold_ack) begin
          nxt    = GRANT;
          bcnt_n = '0;
        end else if (wcnt == WLAST) begin
          nxt     = COOL;
          err_set = 1'b1;
        end else begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      GRANT: begin
        if (!dma_req) begin
          nxt  = COOL;
          done = 1'b1;
        end else if (beat) begin
          if (bcnt == BLAST) begin
            nxt  = COOL;
            done = 1'b1;
          end else begin
            bcnt_n = bcnt + BW'(1);
          end
        end
      end
      COOL: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign hold    = (state == HOLD) || (state == GRANT);
  assign dma_gnt = (state == GRANT);

  always_comb begin
    if (dma_gnt) begin
      mem_we   = beat & dma_we;
      mem_addr = dma_addr;
      mem_wd   = dma_wd;
    end else begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
    end
  end

  assign cpu_rd = mem_rd;
  assign dma_rd = mem_rd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario tasks with a write scoreboard and a small
// behavioural dmem.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        hold;
  logic        hold_ack;
  logic        dma_req;
  logic        dma_valid;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wd;
  logic [31:0] dma_rd;
  logic        dma_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        err;
  logic [15:0] grants;

  logic        ack_en = 1'b0;
  logic        ack_force = 1'b0;
  logic [31:0] mem [0:255];

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sbq[$];
  int  pass_cnt = 0;
  int  total = 0;
  int  exp_grants = 0;

  always #5 clk = ~clk;

  assign hold_ack = ack_en ? hold : ack_force;
  assign mem_rd = mem[mem_addr[9:2]];

  always @(posedge clk)
    if (mem_we)
      mem[mem_addr[9:2]] <= mem_wd;

  dmem_arbiter #(
    .WIDE(32),
    .MAX_BURST(8),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd),
    .hold(hold),
    .hold_ack(hold_ack),
    .dma_req(dma_req),
    .dma_valid(dma_valid),
    .dma_we(dma_we),
    .dma_addr(dma_addr),
    .dma_wd(dma_wd),
    .dma_rd(dma_rd),
    .dma_gnt(dma_gnt),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wd(mem_wd),
    .mem_rd(mem_rd),
    .err(err),
    .grants(grants)
  );

  task automatic test_reset();
    rst = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h0;
    cpu_wd = 32'h0;
    dma_req = 1'b0;
    dma_valid = 1'b0;
    dma_we = 1'b0;
    dma_addr = 32'h0;
    dma_wd = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (hold !== 1'b0) $display("FAIL reset_hold got=%0b exp=0", hold);
    else pass_cnt++;
    total++;
    if (dma_gnt !== 1'b0) $display("FAIL reset_gnt got=%0b exp=0", dma_gnt);
    else pass_cnt++;
    total++;
    if (err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", err);
    else pass_cnt++;
    total++;
    if (grants !== 16'd0) $display("FAIL reset_grants got=%0d exp=0", grants);
    else pass_cnt++;
  endtask

  task automatic test_cpu_only();
    @(negedge clk);
    cpu_we = 1'b1;
    cpu_addr = 32'h40;
    cpu_wd = 32'hDEADBEEF;
    #1;
    total++;
    if (mem_we !== 1'b1) $display("FAIL cpu_we_pass got=%0b exp=1", mem_we);
    else pass_cnt++;
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    total++;
    if (cpu_rd !== 32'hDEADBEEF) $display("FAIL cpu_lw got=%h exp=deadbeef", cpu_rd);
    else pass_cnt++;
    total++;
    if (dma_rd !== 32'hDEADBEEF) $display("FAIL dma_rd_mirror got=%h exp=deadbeef", dma_rd);
    else pass_cnt++;
    total++;
    if (hold !== 1'b0) $display("FAIL cpu_hold got=%0b exp=0", hold);
    else pass_cnt++;
  endtask

  task automatic test_basic_burst();
    wr_t e;
    ack_en = 1'b1;
    @(negedge clk);
    dma_req = 1'b1;
    dma_valid = 1'b0;
    dma_we = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (hold !== 1'b1 || dma_gnt !== 1'b0)
      $display("FAIL basic_hold got=%0b%0b exp=10", hold, dma_gnt);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dma_valid = 1'b1;
      dma_addr = 32'h100 + 32'(4 * i);
      dma_wd = 32'hA000_0000 + 32'(i);
      sbq.push_back('{a: dma_addr, d: dma_wd});
      #1;
      total++;
      if (dma_gnt !== 1'b1) $display("FAIL basic_gnt%0d got=%0b exp=1", i, dma_gnt);
      else pass_cnt++;
      total++;
      if (mem_we !== 1'b1 || sbq.size() == 0) begin
        $display("FAIL basic_beat%0d mem_we=%0b exp=1", i, mem_we);
      end else begin
        e = sbq.pop_front();
        if (mem_addr !== e.a || mem_wd !== e.d)
          $display("FAIL basic_beat%0d got=%h/%h exp=%h/%h", i, mem_addr, mem_wd, e.a, e.d);
        else pass_cnt++;
      end
    end
    @(negedge clk);
    dma_req = 1'b0;
    dma_valid = 1'b0;
    #1;
    total++;
    if (dma_gnt !== 1'b1 || mem_we !== 1'b0)
      $display("FAIL basic_last gnt=%0b we=%0b exp=1/0", dma_gnt, mem_we);
    else pass_cnt++;
    exp_grants++;
    @(negedge clk);
    #1;
    total++;
    if (dma_gnt !== 1'b0 || hold !== 1'b0)
      $display("FAIL basic_cool got=%0b%0b exp=00", hold, dma_gnt);
    else pass_cnt++;
    total++;
    if (grants !== 16'(exp_grants))
      $display("FAIL basic_grants got=%0d exp=%0d", grants, exp_grants);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem[64 + i] !== 32'hA000_0000 + 32'(i))
        $display("FAIL basic_mem%0d got=%h exp=%h", i, mem[64 + i], 32'hA000_0000 + 32'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_burst_cap();
    wr_t e;
    int  idx = 0;
    int  run = -1;
    int  gap = 0;
    int  cyc = 0;
    int  beats[4] = '{0, 0, 0, 0};
    logic prev_gnt = 1'b0;
    ack_en = 1'b1;
    for (int i = 0; i < 12; i++)
      sbq.push_back('{a: 32'h200 + 32'(4 * i), d: 32'hB000_0000 + 32'(i)});
    do begin
      @(negedge clk);
      if (idx < 12) begin
        dma_req = 1'b1;
        dma_valid = 1'b1;
        dma_we = 1'b1;
        dma_addr = 32'h200 + 32'(4 * idx);
        dma_wd = 32'hB000_0000 + 32'(idx);
      end else begin
        dma_req = 1'b0;
        dma_valid = 1'b0;
      end
      #1;
      if (dma_gnt && !prev_gnt) run++;
      if (!dma_gnt && run == 0) gap++;
      if (mem_we) begin
        total++;
        if (sbq.size() == 0) begin
          $display("FAIL cap_beat%0d unexpected write %h", idx, mem_addr);
        end else begin
          e = sbq.pop_front();
          if (mem_addr !== e.a || mem_wd !== e.d)
            $display("FAIL cap_beat%0d got=%h/%h exp=%h/%h", idx, mem_addr, mem_wd, e.a, e.d);
          else pass_cnt++;
        end
        if (run >= 0 && run < 4) beats[run]++;
        idx++;
      end
      prev_gnt = dma_gnt;
      cyc++;
    end while (!(idx >= 12 && !hold && !dma_gnt) && cyc < 80);
    exp_grants += 2;
    total++;
    if (cyc >= 80) $display("FAIL cap_timeout idx=%0d exp=12", idx);
    else pass_cnt++;
    total++;
    if (run !== 1) $display("FAIL cap_runs got=%0d exp=2", run + 1);
    else pass_cnt++;
    total++;
    if (beats[0] !== 8 || beats[1] !== 4)
      $display("FAIL cap_beats got=%0d,%0d exp=8,4", beats[0], beats[1]);
    else pass_cnt++;
    total++;
    if (gap !== 3) $display("FAIL cap_gap got=%0d exp=3", gap);
    else pass_cnt++;
    total++;
    if (grants !== 16'(exp_grants))
      $display("FAIL cap_grants got=%0d exp=%0d", grants, exp_grants);
    else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (mem[128 + i] !== 32'hB000_0000 + 32'(i))
        $display("FAIL cap_mem%0d got=%h exp=%h", i, mem[128 + i], 32'hB000_0000 + 32'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_race();
    ack_en = 1'b0;
    ack_force = 1'b0;
    @(negedge clk);
    dma_req = 1'b1;
    dma_valid = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (hold !== 1'b1) $display("FAIL race_hold got=%0b exp=1", hold);
    else pass_cnt++;
    dma_req = 1'b0;
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    #1;
    total++;
    if (hold !== 1'b0 || dma_gnt !== 1'b0)
      $display("FAIL race_drop got=%0b%0b exp=00", hold, dma_gnt);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total++;
    if (dma_gnt !== 1'b0 || grants !== 16'(exp_grants))
      $display("FAIL race_after gnt=%0b grants=%0d exp=0/%0d", dma_gnt, grants, exp_grants);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    ack_force = 1'b0;
    @(negedge clk);
    dma_req = 1'b1;
    for (int r = 0; r < 2; r++) begin
      int   hc = 0;
      int   cyc = 0;
      logic saw_gnt = 1'b0;
      do begin
        @(negedge clk);
        #1;
        cyc++;
      end while (!hold && cyc < 10);
      while (hold && cyc < 60) begin
        hc++;
        if (dma_gnt) saw_gnt = 1'b1;
        @(negedge clk);
        #1;
        cyc++;
      end
      total++;
      if (hc !== 16) $display("FAIL to_hold_cycles%0d got=%0d exp=16", r, hc);
      else pass_cnt++;
      total++;
      if (saw_gnt !== 1'b0) $display("FAIL to_gnt%0d got=1 exp=0", r);
      else pass_cnt++;
      total++;
      if (err !== 1'b1) $display("FAIL to_err%0d got=%0b exp=1", r, err);
      else pass_cnt++;
    end
    dma_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (grants !== 16'(exp_grants) || err !== 1'b1)
      $display("FAIL to_after grants=%0d err=%0b exp=%0d/1", grants, err, exp_grants);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    ack_en = 1'b1;
    @(negedge clk);
    cpu_we = 1'b1;
    cpu_addr = 32'h300;
    cpu_wd = 32'h1111_1111;
    @(negedge clk);
    cpu_we = 1'b0;
    dma_req = 1'b1;
    dma_valid = 1'b0;
    repeat (2) @(negedge clk);
    dma_valid = 1'b1;
    dma_we = 1'b1;
    dma_addr = 32'h300;
    dma_wd = 32'h2222_2222;
    #1;
    total++;
    if (dma_gnt !== 1'b1 || mem_we !== 1'b1)
      $display("FAIL rstmid_pre gnt=%0b we=%0b exp=1/1", dma_gnt, mem_we);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total++;
    if (hold !== 1'b0 || dma_gnt !== 1'b0)
      $display("FAIL rstmid_async got=%0b%0b exp=00", hold, dma_gnt);
    else pass_cnt++;
    total++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h300)
      $display("FAIL rstmid_mux we=%0b addr=%h exp=0/300", mem_we, mem_addr);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    dma_req = 1'b0;
    dma_valid = 1'b0;
    #1;
    total++;
    if (mem[8'hC0] !== 32'h1111_1111)
      $display("FAIL rstmid_mem got=%h exp=11111111", mem[8'hC0]);
    else pass_cnt++;
    total++;
    if (err !== 1'b0 || grants !== 16'd0)
      $display("FAIL rstmid_clear err=%0b grants=%0d exp=0/0", err, grants);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_basic_burst();
    test_burst_cap();
    test_race();
    test_timeout();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
